// File: rtl/test_light_seq.sv
// Four-phase traffic-light LED sequencer.
// One LED at a time, led_1 -> led_4 -> led_1, each held for Tn cycles.
module test_light_seq #(
   parameter int unsigned T1    = 8,
   parameter int unsigned T2    = 4,
   parameter int unsigned T3    = 8,
   parameter int unsigned T4    = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic clk,
   input  logic reset,
   output logic led_1,
   output logic led_2,
   output logic led_3,
   output logic led_4
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PH1  = 3'd1,
      PH2  = 3'd2,
      PH3  = 3'd3,
      PH4  = 3'd4
   } state_t;

   // A zero dwell is stretched to one cycle so no phase is skipped
   localparam int unsigned E1 = (T1 == 0) ? 1 : T1;
   localparam int unsigned E2 = (T2 == 0) ? 1 : T2;
   localparam int unsigned E3 = (T3 == 0) ? 1 : T3;
   localparam int unsigned E4 = (T4 == 0) ? 1 : T4;

   localparam logic [CNT_W-1:0] L1 = CNT_W'(E1 - 1);
   localparam logic [CNT_W-1:0] L2 = CNT_W'(E2 - 1);
   localparam logic [CNT_W-1:0] L3 = CNT_W'(E3 - 1);
   localparam logic [CNT_W-1:0] L4 = CNT_W'(E4 - 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         {led_4, led_3, led_2, led_1} <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               state <= PH1;
               cnt   <= L1;
               {led_4, led_3, led_2, led_1} <= 4'b0001;
            end
            PH1: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= PH2;
                  cnt   <= L2;
                  {led_4, led_3, led_2, led_1} <= 4'b0010;
               end
            end
            PH2: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= PH3;
                  cnt   <= L3;
                  {led_4, led_3, led_2, led_1} <= 4'b0100;
               end
            end
            PH3: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= PH4;
                  cnt   <= L4;
                  {led_4, led_3, led_2, led_1} <= 4'b1000;
               end
            end
            PH4: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= PH1;
                  cnt   <= L1;
                  {led_4, led_3, led_2, led_1} <= 4'b0001;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               {led_4, led_3, led_2, led_1} <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_test_light_seq.sv
// Bench for test_light_seq: reference model feeds a scoreboard,
// plus directed checks for reset, dwell counts and state recovery.
module tb_test_light_seq;

   logic clk;
   logic reset;
   logic a1, a2, a3, a4;
   logic b1, b2, b3, b4;
   logic [3:0] leds0, leds1;

   int nchk = 0;
   int nerr = 0;

   test_light_seq dut (
      .clk   (clk),
      .reset (reset),
      .led_1 (a1),
      .led_2 (a2),
      .led_3 (a3),
      .led_4 (a4)
   );

   test_light_seq #(
      .T1 (1),
      .T2 (0),
      .T3 (3),
      .T4 (2)
   ) dut2 (
      .clk   (clk),
      .reset (reset),
      .led_1 (b1),
      .led_2 (b2),
      .led_3 (b3),
      .led_4 (b4)
   );

   assign leds0 = {a4, a3, a2, a1};
   assign leds1 = {b4, b3, b2, b1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int teff(input int t);
      return (t == 0) ? 1 : t;
   endfunction

   function automatic logic [3:0] dec(input int ph);
      return (ph == 0) ? 4'b0000 : 4'(1 << (ph - 1));
   endfunction

   // Reference model: phase index plus cycles elapsed in that phase
   int ta[4] = '{8, 4, 8, 4};
   int tb[4] = '{1, 0, 3, 2};
   int ph0 = 0, el0 = 0, ph1 = 0, el1 = 0;
   bit inj = 1'b0;
   logic [3:0] q0[$];
   logic [3:0] q1[$];

   always @(negedge reset) begin
      ph0 = 0; el0 = 0;
      ph1 = 0; el1 = 0;
   end

   always @(posedge clk) begin
      if (!reset) begin
         ph0 = 0; el0 = 0;
         ph1 = 0; el1 = 0;
      end else begin
         if (inj) begin
            ph0 = 0; el0 = 0; inj = 1'b0;
         end else if (ph0 == 0) begin
            ph0 = 1; el0 = 1;
         end else if (el0 >= teff(ta[ph0-1])) begin
            ph0 = (ph0 % 4) + 1; el0 = 1;
         end else begin
            el0++;
         end
         if (ph1 == 0) begin
            ph1 = 1; el1 = 1;
         end else if (el1 >= teff(tb[ph1-1])) begin
            ph1 = (ph1 % 4) + 1; el1 = 1;
         end else begin
            el1++;
         end
      end
      q0.push_back(dec(ph0));
      q1.push_back(dec(ph1));
   end

   always @(negedge clk) begin
      if (q0.size() > 0) chk("sb_dut", 32'(leds0), 32'(q0.pop_front()));
      if (q1.size() > 0) chk("sb_dut2", 32'(leds1), 32'(q1.pop_front()));
   end

   int cnt_hi[4];
   int onehot_bad;
   bit found;
   logic [3:0] pat[7] = '{4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8};

   initial begin
      reset = 1'b0;
      #1;
      chk("reset_now", 32'(leds0), 32'h0);
      repeat (400) @(negedge clk);

      // Ten full periods of the default sequencer
      reset = 1'b1;
      onehot_bad = 0;
      for (int i = 0; i < 4; i++) cnt_hi[i] = 0;
      for (int c = 0; c < 240; c++) begin
         @(negedge clk);
         #1;
         if (!$onehot0(leds0)) onehot_bad++;
         for (int i = 0; i < 4; i++) if (leds0[i]) cnt_hi[i]++;
      end
      chk("onehot_bad", 32'(onehot_bad), 32'd0);
      chk("hi_led1", 32'(cnt_hi[0]), 32'd80);
      chk("hi_led2", 32'(cnt_hi[1]), 32'd40);
      chk("hi_led3", 32'(cnt_hi[2]), 32'd80);
      chk("hi_led4", 32'(cnt_hi[3]), 32'd40);

      // Reset asserted in the middle of PH3
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         #1;
         if (leds0 == 4'b0100) found = 1'b1;
      end
      chk("ph3_seen", 32'(found), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_dut", 32'(leds0), 32'h0);
      chk("async_dut2", 32'(leds1), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         #1;
         chk("pat_dut2", 32'(leds1), 32'(pat[i % 7]));
         if (i < 8) chk("restart_led1", 32'(leds0), 32'h1);
         else if (i < 12) chk("then_led2", 32'(leds0), 32'h2);
      end

      // Illegal state encoding recovers through IDLE
      @(negedge clk);
      force dut.state = 3'd7;
      inj = 1'b1;
      #1 release dut.state;
      @(negedge clk);
      #1;
      chk("illegal_idle", 32'(leds0), 32'h0);
      @(negedge clk);
      #1;
      chk("illegal_ph1", 32'(leds0), 32'h1);

      repeat (30) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
